// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and constants for the clock-ratio meter and related pin-sampling logic.
package mcu_clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meter_state_t;

  localparam int SYNC_STAGES_MIN = 2;

  // All-ones value for a counter of width w. A 32-bit shift wraps to 0 at w=32, so the result is still all ones.
  function automatic logic [31:0] CNT_MAX(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/clk_ratio_meter_if.sv
// Signal bundle between the meter and its user: measured input in, results out.
interface clk_ratio_meter_if #(
  parameter int CNT_W = 16
);
  logic                      en;
  logic                      clk_meas;
  logic [CNT_W-1:0]          period_o;
  logic [CNT_W-1:0]          high_o;
  logic                      valid_o;
  logic                      timeout_o;
  mcu_clk_pkg::meter_state_t state_o;

  // valid_o is a one-cycle strobe with no ready: period_o/high_o change only in
  // the cycle valid_o is high and hold otherwise, so a consumer may sample them
  // on the strobe or any later cycle.
  modport master (
    output en, clk_meas,
    input  period_o, high_o, valid_o, timeout_o, state_o
  );

  modport slave (
    input  en, clk_meas,
    output period_o, high_o, valid_o, timeout_o, state_o
  );
endinterface

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin with one-cycle rise and fall pulses.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              s_d;
  logic              s;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_d    <= sync_q[STAGES-1];
    end
  end

  assign s      = sync_q[STAGES-1];
  assign rise_o = s & ~s_d;
  assign fall_o = ~s & s_d;
endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of an asynchronous clk_meas in clk_in cycles,
// reporting each completed period with a one-cycle valid strobe.
module clk_ratio_meter
  import mcu_clk_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  clk_ratio_meter_if.slave bus
);
  localparam int               STAGES_EFF = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             rise;
  logic             fall;
  meter_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_lat;
  logic             high_seen;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             timeout_q;

  sync_edge_det #(.STAGES(STAGES_EFF)) u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (bus.clk_meas),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      high_lat  <= '0;
      high_seen <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Dropping enable beats every other event, including a same-cycle rise.
      if (!bus.en) begin
        state     <= IDLE;
        cnt       <= '0;
        high_seen <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            // After a timeout cnt parks at its ceiling here until the next rise.
            if (rise) begin
              cnt       <= CNT_ONE;
              high_seen <= 1'b0;
              state     <= MEAS;
            end
          end
          MEAS: begin
            if (rise) begin
              period_q  <= cnt;
              high_q    <= high_seen ? high_lat : cnt;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              cnt       <= CNT_ONE;
              high_seen <= 1'b0;
            end else if (cnt == CNT_TOP) begin
              timeout_q <= 1'b1;
              state     <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall) begin
                high_lat  <= cnt;
                high_seen <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period_o  = period_q;
  assign bus.high_o    = high_q;
  assign bus.valid_o   = valid_q;
  assign bus.timeout_o = timeout_q;
  assign bus.state_o   = state;
endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: timestamp-based period model plus literal spot checks.
module tb_clk_ratio_meter;
  import mcu_clk_pkg::*;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;
  localparam int LIMIT = (1 << CNT_W) - 1;
  localparam int HIST  = 8192;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  always #5 clk_in = ~clk_in;

  clk_ratio_meter_if #(.CNT_W(CNT_W)) bus ();

  clk_ratio_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;

  // ---------------- model: rising-edge timestamps of the driven waveform
  int               cyc = 0;
  bit               hist [0:HIST-1];
  bit               armed, has_ref, fall_seen;
  int               ref_t, fall_t;
  bit               m_valid, m_to;
  logic [CNT_W-1:0] m_period, m_high;
  logic [2*CNT_W-1:0] exp_q[$];

  always @(posedge clk_in) begin
    int  t;
    bit  rise, fall;
    cyc = cyc + 1;
    if (cyc - 1 < HIST) hist[cyc-1] = bus.clk_meas;
    m_valid = 1'b0;
    if (!rst_n) begin
      armed = 0; has_ref = 0; fall_seen = 0;
      m_to = 0; m_period = '0; m_high = '0;
      exp_q.delete();
    end else if (!bus.en) begin
      armed = 0; has_ref = 0; m_to = 0;
    end else if (!armed) begin
      armed = 1;
    end else begin
      t    = cyc - LAT;
      rise = (t >= 1 && t < HIST) ? (hist[t] && !hist[t-1]) : 1'b0;
      fall = (t >= 1 && t < HIST) ? (!hist[t] && hist[t-1]) : 1'b0;
      if (rise) begin
        if (has_ref) begin
          m_valid  = 1'b1;
          m_period = CNT_W'(t - ref_t);
          m_high   = fall_seen ? CNT_W'(fall_t - ref_t) : CNT_W'(t - ref_t);
          m_to     = 1'b0;
          exp_q.push_back({m_period, m_high});
        end
        has_ref   = 1;
        ref_t     = t;
        fall_seen = 0;
      end else if (fall && has_ref) begin
        fall_seen = 1;
        fall_t    = t;
      end else if (has_ref && (t - ref_t) == LIMIT) begin
        m_to    = 1'b1;
        has_ref = 0;
      end
    end
  end

  // ---------------- compare process
  always @(negedge clk_in) begin
    logic [2*CNT_W-1:0] e;
    if (rst_n) begin
      n_checks++;
      if (bus.valid_o !== m_valid || bus.timeout_o !== m_to ||
          bus.period_o !== m_period || bus.high_o !== m_high) begin
        n_fail++;
        $display("FAIL model cyc=%0d got valid=%b to=%b period=%0d high=%0d want valid=%b to=%b period=%0d high=%0d",
                 cyc, bus.valid_o, bus.timeout_o, bus.period_o, bus.high_o, m_valid, m_to, m_period, m_high);
      end
      if (bus.valid_o === 1'b1) begin
        valid_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard cyc=%0d unexpected valid period=%0d high=%0d", cyc, bus.period_o, bus.high_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.period_o, bus.high_o} !== e) begin
            n_fail++;
            $display("FAIL scoreboard cyc=%0d got period=%0d high=%0d want period=%0d high=%0d",
                     cyc, bus.period_o, bus.high_o, e[2*CNT_W-1:CNT_W], e[CNT_W-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic hold(input int n, input bit v);
    repeat (n) begin
      @(posedge clk_in);
      #1 bus.clk_meas = v;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      hold(h, 1'b1);
      hold(l, 1'b0);
    end
  endtask

  task automatic set_en(input bit v);
    @(posedge clk_in);
    #1 bus.en = v;
  endtask

  // ---------------- stimulus
  initial begin
    int v0;
    bus.en       = 1'b0;
    bus.clk_meas = 1'b0;

    // reset held while the input toggles
    wave(2, 2, 3);
    #1;
    check("rst_period", int'(bus.period_o), 0);
    check("rst_high", int'(bus.high_o), 0);
    check("rst_valid", int'(bus.valid_o), 0);
    check("rst_timeout", int'(bus.timeout_o), 0);
    check("rst_state", int'(bus.state_o), int'(IDLE));
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    wave(3, 3, 4);
    check("disabled_no_valid", valid_cnt, 0);

    // divide-by-4, 2 high 2 low
    hold(3, 1'b0);
    set_en(1'b1);
    hold(4, 1'b0);
    v0 = valid_cnt;
    wave(2, 2, 10);
    hold(6, 1'b0);
    check("div4_valid_count", valid_cnt - v0, 9);
    check("div4_period", int'(bus.period_o), 4);
    check("div4_high", int'(bus.high_o), 2);

    // 3/3 then 2/5 duty
    wave(3, 3, 5);
    check("div6_period", int'(bus.period_o), 6);
    check("div6_high", int'(bus.high_o), 3);
    wave(2, 5, 2);
    check("p7_period", int'(bus.period_o), 7);
    check("p7_high", int'(bus.high_o), 2);

    // timeout with input stuck low, then recovery
    wave(5, 5, 3);
    check("p10_period", int'(bus.period_o), 10);
    hold(300, 1'b0);
    check("timeout_set", int'(bus.timeout_o), 1);
    check("timeout_period_kept", int'(bus.period_o), 10);
    check("timeout_state", int'(bus.state_o), int'(ARM));
    v0 = valid_cnt;
    wave(5, 5, 3);
    check("recover_valid_count", valid_cnt - v0, 2);
    check("recover_timeout", int'(bus.timeout_o), 0);
    check("recover_period", int'(bus.period_o), 10);

    // enable dropped mid-measurement
    wave(4, 4, 4);
    hold(4, 1'b1);
    hold(2, 1'b0);
    v0 = valid_cnt;
    set_en(1'b0);
    hold(2, 1'b0);
    wave(4, 4, 3);
    check("en_off_no_valid", valid_cnt - v0, 0);
    check("en_off_state", int'(bus.state_o), int'(IDLE));
    set_en(1'b1);
    hold(2, 1'b0);
    v0 = valid_cnt;
    wave(4, 4, 3);
    hold(4, 1'b0);
    check("reenable_valid_count", valid_cnt - v0, 2);
    check("reenable_period", int'(bus.period_o), 8);
    check("reenable_high", int'(bus.high_o), 4);

    // asynchronous reset between clock edges during MEAS
    wave(4, 4, 2);
    hold(2, 1'b1);
    @(posedge clk_in);
    #2 rst_n = 1'b0;
    bus.clk_meas = 1'b0;
    #1;
    check("async_rst_period", int'(bus.period_o), 0);
    check("async_rst_high", int'(bus.high_o), 0);
    check("async_rst_valid", int'(bus.valid_o), 0);
    check("async_rst_timeout", int'(bus.timeout_o), 0);
    hold(5, 1'b0);
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    hold(3, 1'b0);
    check("after_rst_state", int'(bus.state_o), int'(ARM));
    wave(3, 4, 4);
    hold(4, 1'b0);
    check("after_rst_period", int'(bus.period_o), 7);
    check("after_rst_high", int'(bus.high_o), 3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
